quad_pulse_gen: RTL and testbench
=================================

// Module: quad_pulse_gen
// PURPOSE
//  Quadrature transmitter: turns step commands into A/B encoder waveforms whose
//  phase dwell safely exceeds the input debouncer's 100-cycle sample period.
//  Drives encoder-emulation pins and the loopback path to the debounced decoder.
//  Also tracks the absolute position it has emitted.
// PARAMETERS
//  DWELL_CYCLES  250  clocks each (A,B) phase is held; legal range 2..65535
//  CNT_W         16   width of cmd_count
//  POS_W         32   width of the signed position counter
//  CPR           1024 counts per revolution; used only with the index feature
// PORTS
//  clk        in   1      system clock; all logic is on the rising edge
//  rst        in   1      asynchronous, active-high reset
//  cmd_valid  in   1      step command offered
//  cmd_ready  out  1      block can accept a command (1 only in IDLE)
//  cmd_dir    in   1      1 = forward (A leads B), 0 = reverse
//  cmd_count  in   CNT_W  number of quadrature edges to emit
//  Aout       out  1      quadrature channel A, registered
//  Bout       out  1      quadrature channel B, registered
//  Zout       out  1      index pulse (see CONFIGURATION)
//  busy       out  1      1 in RUN or TAIL
//  done       out  1      one-cycle pulse when a command completes
//  position   out  POS_W  signed count of emitted edges, +1 fwd / -1 rev
// BEHAVIOUR
//  - Reset values: Aout=0, Bout=0, busy=0, done=0, position=0, phase=00,
//    cmd_ready=1, and dwell counter=0.
//  - Phase sequence (A,B): forward 00->10->11->01->00; reverse is the same
//    sequence walked backwards. Exactly one of A or B toggles per edge.
//  - Handshake: a command is accepted on a cycle where cmd_valid && cmd_ready.
//    cmd_dir and cmd_count are latched on that cycle. Inputs are ignored
//    outside IDLE.
//  - FSM IDLE:
//    - On accept with count==0, go to TAIL with dwell=0 (done on the next cycle).
//    - On accept with count>0, go to RUN; load remaining=count; load dwell=DWELL_CYCLES-1.
//  - FSM RUN: dwell decrements every cycle. When dwell==0:
//    - advance the phase one edge;
//    - update position;
//    - decrement remaining;
//    - reload dwell=DWELL_CYCLES-1.
//    After the edge that brings remaining to 0, go to TAIL.
//  - FSM TAIL:
//    - holds the final phase for a full DWELL_CYCLES, so the last state is stable
//      to the debouncer;
//    - then pulses done for 1 cycle and returns to IDLE.
//    For a zero-count command, TAIL lasts 1 cycle.
//  - Latency: the first edge appears DWELL_CYCLES clocks after the accept cycle.
//    Edge k is at k*DWELL_CYCLES. done fires (count+1)*DWELL_CYCLES clocks after
//    accept.
//  - Arithmetic: position wraps modulo 2^POS_W (two's complement, no saturation).
//    remaining never underflows.
//  - cmd_ready is combinational from state only; it does not depend on cmd_valid.
//  - Reset mid-operation: everything returns to its reset values on the
//    rst assertion edge. Any partial command is discarded and no done is issued.
//  - Aout/Bout hold their final phase between commands. A new command continues
//    from the current phase (no jump back to 00).
// CONFIGURATION
//  QUAD_PULSE_GEN_INDEX_EN
//  - Defined: keep rev_pos, a counter in 0..CPR-1 that steps with every edge
//    (+1 fwd, -1 rev) and wraps at both ends (CPR-1 -> 0 and 0 -> CPR-1).
//    Zout is a register equal to (rev_pos==0); its reset value is 1.
//  - Not defined: no rev_pos logic; the Zout port remains, tied to constant 0.
// STRUCTURE
//  - quad_pulse_gen_pkg holds:
//    - phase encodings PH_00/PH_10/PH_11/PH_01 and the next/prev phase functions;
//    - the FSM state encoding IDLE/RUN/TAIL.
//  - One sub-module, quad_dwell_timer: loadable down-counter with a load input,
//    a load value and a zero flag, 16 bits.
//  - Everything else stays in the top level.
// TESTING
//  1 Reset: assert rst mid-cycle -> Aout=Bout=0, position=0, cmd_ready=1,
//    done=0 with no clock edge.
//  2 Forward: DWELL=4, dir=1, count=5 -> AB 10,11,01,00,10 at cycles
//    4,8,12,16,20; done at 24; position=5.
//  3 Reverse wrap: from position 0, dir=0, count=3 -> AB 01,11,10;
//    position=-3 (0xFFFFFFFD).
//  4 Zero count: count=0 -> no AB change; done 1 cycle after accept;
//    cmd_ready back to 1 the next cycle.
//  5 Busy rejection and mid-run reset: cmd_valid held high during RUN with
//    new values -> ignored. rst during RUN -> no done, position=0.
//  6 INDEX_EN, CPR=4: Zout=1 after reset; fwd count=4 -> Zout=0 for 3 edges,
//    1 on the 4th. rev count=1 from 0 -> rev_pos=3, Zout=0.

Source files
------------

// File: rtl/quad_pulse_gen_pkg.sv
// Shared types for the quadrature pulse generator: phase encodings, phase
// stepping helpers and the controller state encoding.
package quad_pulse_gen_pkg;

    // Width of the dwell down-counter
    localparam int unsigned DWELL_W = 16;

    // (A,B) phase encodings; bit 1 is A, bit 0 is B
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_10 = 2'b10,
        PH_11 = 2'b11,
        PH_01 = 2'b01
    } phase_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        TAIL = 2'b10
    } state_e;

    // Forward step: A leads B
    function automatic phase_e next_phase(input phase_e ph);
        case (ph)
            PH_00:   return PH_10;
            PH_10:   return PH_11;
            PH_11:   return PH_01;
            default: return PH_00;
        endcase
    endfunction

    // Reverse step: same ring walked backwards
    function automatic phase_e prev_phase(input phase_e ph);
        case (ph)
            PH_00:   return PH_01;
            PH_01:   return PH_11;
            PH_11:   return PH_10;
            default: return PH_00;
        endcase
    endfunction

endpackage

// File: rtl/quad_dwell_timer.sv
// Loadable 16-bit down-counter that parks at zero and flags it.
module quad_dwell_timer
    import quad_pulse_gen_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt_q;

    // Load has priority; otherwise count down and hold at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/quad_pulse_gen.sv
// Quadrature transmitter: emits cmd_count A/B edges, each phase held for
// DWELL_CYCLES clocks, then holds the final phase for one more dwell before
// pulsing done. Tracks the signed emitted position.
// Optional index output enabled by defining QUAD_PULSE_GEN_INDEX_EN.
module quad_pulse_gen
    import quad_pulse_gen_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 250,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned POS_W        = 32,
    parameter int unsigned CPR          = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_dir,
    input  logic [CNT_W-1:0]        cmd_count,
    output logic                    Aout,
    output logic                    Bout,
    output logic                    Zout,
    output logic                    busy,
    output logic                    done,
    output logic signed [POS_W-1:0] position
);

    if (DWELL_CYCLES < 2 || DWELL_CYCLES > 65535) begin : g_bad_dwell
        $error("DWELL_CYCLES out of range 2..65535");
    end
    if (CPR < 2) begin : g_bad_cpr
        $error("CPR must be at least 2");
    end

    localparam logic [DWELL_W-1:0] DWELL_RELOAD = DWELL_W'(DWELL_CYCLES - 1);

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [POS_W-1:0]   position_q, position_d;
    logic               done_q, done_d;
    logic               tmr_load;
    logic [DWELL_W-1:0] tmr_val;
    logic               tmr_zero;
    logic               step;

    quad_dwell_timer u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Controller next-state: accept, edge stepping and final hold
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        dir_d       = dir_q;
        remaining_d = remaining_q;
        position_d  = position_q;
        done_d      = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = DWELL_RELOAD;
        step        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d    = cmd_dir;
                    tmr_load = 1'b1;
                    if (cmd_count == '0) begin
                        // Zero-count command: a one-cycle tail
                        state_d = TAIL;
                        tmr_val = '0;
                    end else begin
                        state_d     = RUN;
                        remaining_d = cmd_count;
                    end
                end
            end
            RUN: begin
                if (tmr_zero) begin
                    step        = 1'b1;
                    tmr_load    = 1'b1;
                    phase_d     = dir_q ? next_phase(phase_q) : prev_phase(phase_q);
                    position_d  = dir_q ? position_q + POS_W'(1) : position_q - POS_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    // Reloaded dwell doubles as the final-phase hold in TAIL
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = TAIL;
                    end
                end
            end
            TAIL: begin
                if (tmr_zero) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= PH_00;
            dir_q       <= 1'b0;
            remaining_q <= '0;
            position_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            dir_q       <= dir_d;
            remaining_q <= remaining_d;
            position_q  <= position_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign Aout      = phase_q[1];
    assign Bout      = phase_q[0];
    assign position  = position_q;

`ifdef QUAD_PULSE_GEN_INDEX_EN
    localparam int unsigned RP_W = $clog2(CPR);
    localparam logic [RP_W-1:0] RP_MAX = RP_W'(CPR - 1);

    logic [RP_W-1:0] rev_pos_q, rev_pos_d;
    logic            zout_q;

    // Position within one revolution, wrapping at both ends
    always_comb begin
        rev_pos_d = rev_pos_q;
        if (step) begin
            if (dir_q) begin
                rev_pos_d = (rev_pos_q == RP_MAX) ? '0 : rev_pos_q + RP_W'(1);
            end else begin
                rev_pos_d = (rev_pos_q == '0) ? RP_MAX : rev_pos_q - RP_W'(1);
            end
        end
    end

    // Index register tracks rev_pos==0 in the same cycle rev_pos updates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rev_pos_q <= '0;
            zout_q    <= 1'b1;
        end else begin
            rev_pos_q <= rev_pos_d;
            zout_q    <= (rev_pos_d == '0);
        end
    end

    assign Zout = zout_q;
`else
    logic unused_step;
    assign unused_step = step;
    assign Zout        = 1'b0;
`endif

endmodule

// File: tb/tb_quad_pulse_gen.sv
// Directed self-checking bench for quad_pulse_gen with DWELL_CYCLES=4, CPR=4.
module tb_quad_pulse_gen;

    localparam int unsigned DWELL = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned POS_W = 32;
    localparam int unsigned CPR   = 4;

`ifdef QUAD_PULSE_GEN_INDEX_EN
    localparam logic Z_RST = 1'b1;
`else
    localparam logic Z_RST = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_dir;
    logic [CNT_W-1:0]        cmd_count;
    logic                    Aout;
    logic                    Bout;
    logic                    Zout;
    logic                    busy;
    logic                    done;
    logic signed [POS_W-1:0] position;

    int checks = 0;
    int errors = 0;

    quad_pulse_gen #(
        .DWELL_CYCLES (DWELL),
        .CNT_W        (CNT_W),
        .POS_W        (POS_W),
        .CPR          (CPR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_count (cmd_count),
        .Aout      (Aout),
        .Bout      (Bout),
        .Zout      (Zout),
        .busy      (busy),
        .done      (done),
        .position  (position)
    );

    always #5 clk = ~clk;

    // Offer a command for one clock; returns at the falling edge after accept
    task automatic issue(input logic dir, input int cnt);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_count = CNT_W'(cnt);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({Aout, Bout} !== 2'b00 || position !== '0 || cmd_ready !== 1'b1 ||
            done !== 1'b0 || busy !== 1'b0 || Zout !== Z_RST) begin
            errors++;
            $display("FAIL reset: ab=%b pos=%h rdy=%b done=%b busy=%b z=%b, want 00 0 1 0 0 %b",
                     {Aout, Bout}, position, cmd_ready, done, busy, Zout, Z_RST);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_forward();
        logic [1:0] seq [0:5];
        int k;
        seq = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
        issue(1'b1, 5);
        for (int n = 1; n <= 26; n++) begin
            @(negedge clk);
            k = n / DWELL;
            if (k > 5) k = 5;
            checks++;
            if ({Aout, Bout} !== seq[k]) begin
                errors++;
                $display("FAIL fwd_ab n=%0d: got %b want %b", n, {Aout, Bout}, seq[k]);
            end
            checks++;
            if (position !== POS_W'(k)) begin
                errors++;
                $display("FAIL fwd_pos n=%0d: got %0d want %0d", n, position, k);
            end
            checks++;
            if (done !== (n == 24)) begin
                errors++;
                $display("FAIL fwd_done n=%0d: got %b want %b", n, done, (n == 24));
            end
            checks++;
            if (busy !== (n < 24) || cmd_ready !== (n >= 24)) begin
                errors++;
                $display("FAIL fwd_busy n=%0d: busy=%b rdy=%b want busy=%b", n, busy,
                         cmd_ready, (n < 24));
            end
        end
    endtask

    task automatic test_reverse_wrap();
        logic [1:0] seq [0:3];
        seq = '{2'b00, 2'b01, 2'b11, 2'b10};
        pulse_reset();
        issue(1'b0, 3);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n % DWELL == 0 && n <= 12) begin
                checks++;
                if ({Aout, Bout} !== seq[n / DWELL]) begin
                    errors++;
                    $display("FAIL rev_ab n=%0d: got %b want %b", n, {Aout, Bout},
                             seq[n / DWELL]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || position !== 32'hFFFF_FFFD || Zout !== 1'b0) begin
            errors++;
            $display("FAIL rev_end: done=%b pos=%h z=%b want 1 fffffffd 0", done, position,
                     Zout);
        end
    endtask

    // Starts from phase 10, position -3
    task automatic test_zero_count();
        issue(1'b1, 0);
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_tail: busy=%b rdy=%b done=%b want 1 0 0", busy, cmd_ready, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || cmd_ready !== 1'b1 || {Aout, Bout} !== 2'b10 ||
            position !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL zero_done: done=%b rdy=%b ab=%b pos=%h want 1 1 10 fffffffd", done,
                     cmd_ready, {Aout, Bout}, position);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_pulse: done=%b want 0", done);
        end
    endtask

    // Starts from phase 10, position -3
    task automatic test_busy_and_reset();
        int seen_done;
        issue(1'b1, 2);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_count = CNT_W'(7);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 10) cmd_valid = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || {Aout, Bout} !== 2'b01 || position !== -32'sd1) begin
            errors++;
            $display("FAIL busy_ignore: done=%b ab=%b pos=%h want 1 01 ffffffff", done,
                     {Aout, Bout}, position);
        end
        issue(1'b1, 3);
        for (int n = 1; n <= 6; n++) @(negedge clk);
        checks++;
        if ({Aout, Bout} !== 2'b00 || position !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre: ab=%b pos=%h busy=%b want 00 0 1", {Aout, Bout},
                     position, busy);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({Aout, Bout} !== 2'b00 || position !== '0 || busy !== 1'b0 ||
            cmd_ready !== 1'b1 || done !== 1'b0 || Zout !== Z_RST) begin
            errors++;
            $display("FAIL midrun_rst: ab=%b pos=%h busy=%b rdy=%b done=%b z=%b", {Aout, Bout},
                     position, busy, cmd_ready, done, Zout);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done != 0 || position !== '0) begin
            errors++;
            $display("FAIL midrun_quiet: bad cycles=%0d pos=%h want 0 0", seen_done, position);
        end
    endtask

    task automatic test_index();
        logic exp_z;
        pulse_reset();
        checks++;
        if (Zout !== Z_RST) begin
            errors++;
            $display("FAIL idx_rst: got %b want %b", Zout, Z_RST);
        end
        issue(1'b1, 4);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n % DWELL == 0 && n <= 16) begin
                exp_z = (n == 16) ? Z_RST : 1'b0;
                checks++;
                if (Zout !== exp_z) begin
                    errors++;
                    $display("FAIL idx_fwd n=%0d: got %b want %b", n, Zout, exp_z);
                end
            end
        end
        issue(1'b0, 1);
        for (int n = 1; n <= 8; n++) @(negedge clk);
        checks++;
        if (Zout !== 1'b0 || {Aout, Bout} !== 2'b01 || position !== 32'sd3 || done !== 1'b1) begin
            errors++;
            $display("FAIL idx_rev: z=%b ab=%b pos=%0d done=%b want 0 01 3 1", Zout,
                     {Aout, Bout}, position, done);
        end
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_count = '0;
        test_reset();
        test_forward();
        test_reverse_wrap();
        test_zero_count();
        test_busy_and_reset();
        test_index();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
